kvaz_write_buffer: RTL and testbench

- Posted-write buffer between the Vector-06c bus-side ramdisk (kvaz) request logic and the SDRAM arbiter's VU port.
- Absorbs VU memory writes (18-bit kvaz address + byte) into a small FIFO, so a slow or refreshing SDRAM never costs a bus write.
- Reads are issued ahead of posted writes; read-after-write hazards are resolved by forwarding from the FIFO.

---
 rtl/kvaz_write_buffer.sv | 168 ++++++++++++++++
 tb/tb_kvaz_write_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kvaz_write_buffer.sv
// Posted-write FIFO between the kvaz ramdisk request logic and the SDRAM arbiter VU port.
// Build option: define KVAZ_WBUF_FORWARD_EN to forward reads from pending writes.
module kvaz_write_buffer #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_write,
  input  logic                  in_read,
  input  logic [ADDR_W-1:0]     in_adrs,
  input  logic [7:0]            in_data,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic                  arb_write,
  output logic                  arb_read,
  output logic [ADDR_W-1:0]     arb_adrs,
  output logic [7:0]            arb_data,
  input  logic                  arb_wr_ack,
  input  logic                  arb_rd_ack,
  input  logic [7:0]            arb_rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow
);

  localparam int Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWr   = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;

  logic [ADDR_W-1:0]     fifo_adrs_q [Depth];
  logic [7:0]            fifo_data_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic                  rd_pend_q;
  logic [ADDR_W-1:0]     rd_adrs_q;
  logic                  rd_valid_q;
  logic [7:0]            rd_data_q;
  logic                  overflow_q;

  logic                  push, pop, is_full;
  logic                  rd_accept, rd_hit, rd_fwd, rd_miss, rd_done;
  logic [7:0]            rd_hit_data;

  assign is_full   = (count_q == DepthCnt);
  assign pop       = (state_q == StWr) && arb_wr_ack;
  // A pop in the same cycle frees the slot, so a write on a full FIFO still goes in.
  assign push      = in_write && (!is_full || pop);
  assign rd_accept = in_read && !rd_pend_q;
  assign rd_done   = (state_q == StRd) && arb_rd_ack;

`ifdef KVAZ_WBUF_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins; the write being
  // pushed this cycle is younger than everything stored.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_data = 8'h00;
    for (int i = 0; i < Depth; i++) begin
      if (((DEPTH_LOG2 + 1)'(i) < count_q) &&
          (fifo_adrs_q[rd_ptr_q + DEPTH_LOG2'(i)] == in_adrs)) begin
        rd_hit      = 1'b1;
        rd_hit_data = fifo_data_q[rd_ptr_q + DEPTH_LOG2'(i)];
      end
    end
    if (push && (in_adrs == in_adrs) && in_write) begin
      rd_hit      = 1'b1;
      rd_hit_data = in_data;
    end
  end
`else
  assign rd_hit      = 1'b0;
  assign rd_hit_data = 8'h00;
`endif

  assign rd_fwd  = rd_accept && rd_hit;
  assign rd_miss = rd_accept && !rd_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
`ifdef KVAZ_WBUF_FORWARD_EN
        if (rd_pend_q || rd_miss) begin
          state_d = StRd;
        end else if ((count_q != '0) || push) begin
          state_d = StWr;
        end
`else
        // Without forwarding the read must be ordered after every posted write.
        if ((rd_pend_q || rd_miss) && (count_q == '0) && !push) begin
          state_d = StRd;
        end else if ((count_q != '0) || push) begin
          state_d = StWr;
        end
`endif
      end
      StWr:    if (arb_wr_ack) state_d = StIdle;
      StRd:    if (arb_rd_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adrs_q[wr_ptr_q] <= in_adrs;
      fifo_data_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      rd_pend_q  <= 1'b0;
      rd_adrs_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_valid_q <= rd_fwd || rd_done;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rd_done) begin
        rd_data_q <= arb_rd_data;
      end else if (rd_fwd) begin
        rd_data_q <= rd_hit_data;
      end
      if (rd_miss) begin
        rd_pend_q <= 1'b1;
        rd_adrs_q <= in_adrs;
      end else if (rd_done) begin
        rd_pend_q <= 1'b0;
      end
      if ((in_write && !push) || (in_read && rd_pend_q)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign arb_write = (state_q == StWr);
  assign arb_read  = (state_q == StRd);
  assign arb_adrs  = (state_q == StWr) ? fifo_adrs_q[rd_ptr_q] :
                     (state_q == StRd) ? rd_adrs_q : '0;
  assign arb_data  = (state_q == StWr) ? fifo_data_q[rd_ptr_q] : 8'h00;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign full      = is_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kvaz_write_buffer.sv
// Directed self-checking bench for kvaz_write_buffer; covers both KVAZ_WBUF_FORWARD_EN builds.
module tb_kvaz_write_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_write = 1'b0;
  logic        in_read = 1'b0;
  logic [17:0] in_adrs = '0;
  logic [7:0]  in_data = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        arb_write;
  logic        arb_read;
  logic [17:0] arb_adrs;
  logic [7:0]  arb_data;
  logic        arb_wr_ack = 1'b0;
  logic        arb_rd_ack = 1'b0;
  logic [7:0]  arb_rd_data = '0;
  logic [2:0]  count;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  kvaz_write_buffer #(
    .ADDR_W     (18),
    .DEPTH_LOG2 (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_write    (in_write),
    .in_read     (in_read),
    .in_adrs     (in_adrs),
    .in_data     (in_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .arb_write   (arb_write),
    .arb_read    (arb_read),
    .arb_adrs    (arb_adrs),
    .arb_data    (arb_data),
    .arb_wr_ack  (arb_wr_ack),
    .arb_rd_ack  (arb_rd_ack),
    .arb_rd_data (arb_rd_data),
    .count       (count),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [17:0] a, input logic [7:0] d);
    in_write = 1'b1;
    in_adrs  = a;
    in_data  = d;
    tick();
    in_write = 1'b0;
  endtask

  task automatic rd(input logic [17:0] a);
    in_read = 1'b1;
    in_adrs = a;
    tick();
    in_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expects the FSM in WR; acks once, then lets it reach WR again (or idle if empty).
  task automatic ack_write(input string tag, input logic [17:0] a);
    chk({tag, "_wr"}, {31'd0, arb_write}, 32'd1);
    chk({tag, "_adrs"}, {14'd0, arb_adrs}, {14'd0, a});
    arb_wr_ack = 1'b1;
    tick();
    arb_wr_ack = 1'b0;
    chk({tag, "_idle"}, {31'd0, arb_write}, 32'd0);
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_arb_write", {31'd0, arb_write}, 32'd0);
    chk("rst_arb_read", {31'd0, arb_read}, 32'd0);
    chk("rst_arb_adrs", {14'd0, arb_adrs}, 32'd0);
    chk("rst_arb_data", {24'd0, arb_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single write, acked after three cycles.
    wr(18'h00010, 8'hA5);
    chk("w1_arb_write", {31'd0, arb_write}, 32'd1);
    chk("w1_adrs", {14'd0, arb_adrs}, 32'h10);
    chk("w1_data", {24'd0, arb_data}, 32'hA5);
    chk("w1_count", {29'd0, count}, 32'd1);
    tick();
    tick();
    chk("w1_hold", {31'd0, arb_write}, 32'd1);
    arb_wr_ack = 1'b1;
    tick();
    arb_wr_ack = 1'b0;
    chk("w1_count_after", {29'd0, count}, 32'd0);
    chk("w1_write_low", {31'd0, arb_write}, 32'd0);
    tick();
    chk("w1_stay_idle", {31'd0, arb_write}, 32'd0);

    // Fill with acks withheld; fifth write is dropped.
    for (int i = 1; i <= 5; i++) begin
      wr(18'(i), 8'(i * 8'h11));
      if (i == 4) begin
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
      end
    end
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_count", {29'd0, count}, 32'd4);
    chk("drop_data1", {24'd0, arb_data}, 32'h11);
    for (int k = 1; k <= 4; k++) begin
      ack_write("drain", 18'(k));
    end
    chk("drain_count", {29'd0, count}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
    do_reset();
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Write accepted on a full FIFO in the same cycle as a pop.
    for (int i = 0; i < 4; i++) begin
      wr(18'h20 + 18'(i), 8'h40 + 8'(i));
    end
    chk("pp_full", {31'd0, full}, 32'd1);
    in_write   = 1'b1;
    in_adrs    = 18'h24;
    in_data    = 8'h44;
    arb_wr_ack = 1'b1;
    tick();
    in_write   = 1'b0;
    arb_wr_ack = 1'b0;
    chk("pp_count", {29'd0, count}, 32'd4);
    chk("pp_no_ovf", {31'd0, overflow}, 32'd0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) chk("pp_last_data", {24'd0, arb_data}, 32'h44);
      ack_write("pp", 18'h20 + 18'(k));
    end
    chk("pp_empty", {29'd0, count}, 32'd0);

`ifdef KVAZ_WBUF_FORWARD_EN
    // Youngest of two matching entries is forwarded.
    wr(18'h02000, 8'h3C);
    wr(18'h02000, 8'h7E);
    rd(18'h02000);
    chk("fwd_valid", {31'd0, rd_valid}, 32'd1);
    chk("fwd_data", {24'd0, rd_data}, 32'h7E);
    chk("fwd_no_read", {31'd0, arb_read}, 32'd0);
    tick();
    chk("fwd_pulse", {31'd0, rd_valid}, 32'd0);
    ack_write("fwd_a", 18'h02000);
    chk("fwd_no_read2", {31'd0, arb_read}, 32'd0);
    ack_write("fwd_b", 18'h02000);
    chk("fwd_no_read3", {31'd0, arb_read}, 32'd0);

    // Read miss waits behind an in-flight write.
    wr(18'h00050, 8'h12);
    rd(18'h3FFFF);
    chk("miss_wait", {31'd0, arb_read}, 32'd0);
    tick();
    chk("miss_wait2", {31'd0, arb_read}, 32'd0);
    arb_wr_ack = 1'b1;
    tick();
    arb_wr_ack = 1'b0;
    chk("miss_gap", {31'd0, arb_read}, 32'd0);
    tick();
    chk("miss_read", {31'd0, arb_read}, 32'd1);
    chk("miss_adrs", {14'd0, arb_adrs}, 32'h3FFFF);
    arb_rd_data = 8'hC3;
    arb_rd_ack  = 1'b1;
    tick();
    arb_rd_ack  = 1'b0;
    chk("miss_valid", {31'd0, rd_valid}, 32'd1);
    chk("miss_data", {24'd0, rd_data}, 32'hC3);
    tick();

    // Simultaneous write and read to the same address.
    in_write = 1'b1;
    in_read  = 1'b1;
    in_adrs  = 18'h00100;
    in_data  = 8'h99;
    tick();
    in_write = 1'b0;
    in_read  = 1'b0;
    chk("sim_valid", {31'd0, rd_valid}, 32'd1);
    chk("sim_data", {24'd0, rd_data}, 32'h99);
    chk("sim_count", {29'd0, count}, 32'd1);
    chk("sim_no_read", {31'd0, arb_read}, 32'd0);
    ack_write("sim", 18'h00100);
`else
    // Read is ordered behind both pending writes.
    wr(18'h00030, 8'h01);
    wr(18'h00031, 8'h02);
    rd(18'h00040);
    chk("nf_wait", {31'd0, arb_read}, 32'd0);
    chk("nf_no_fwd", {31'd0, rd_valid}, 32'd0);
    arb_wr_ack = 1'b1;
    tick();
    arb_wr_ack = 1'b0;
    chk("nf_wait2", {31'd0, arb_read}, 32'd0);
    tick();
    chk("nf_wr2", {31'd0, arb_write}, 32'd1);
    chk("nf_wr2_adrs", {14'd0, arb_adrs}, 32'h31);
    chk("nf_wait3", {31'd0, arb_read}, 32'd0);
    arb_wr_ack = 1'b1;
    tick();
    arb_wr_ack = 1'b0;
    chk("nf_gap", {31'd0, arb_read}, 32'd0);
    tick();
    chk("nf_read", {31'd0, arb_read}, 32'd1);
    chk("nf_adrs", {14'd0, arb_adrs}, 32'h40);
    chk("nf_excl", {31'd0, arb_write}, 32'd0);
    arb_rd_data = 8'h5A;
    arb_rd_ack  = 1'b1;
    tick();
    arb_rd_ack  = 1'b0;
    chk("nf_valid", {31'd0, rd_valid}, 32'd1);
    chk("nf_data", {24'd0, rd_data}, 32'h5A);
    chk("nf_read_low", {31'd0, arb_read}, 32'd0);
    tick();
    chk("nf_pulse", {31'd0, rd_valid}, 32'd0);
    chk("nf_hold", {24'd0, rd_data}, 32'h5A);
`endif

    // Reset during RD with three writes queued; a late read ack is ignored.
    do_reset();
    rd(18'h00155);
    chk("rr_read", {31'd0, arb_read}, 32'd1);
    chk("rr_adrs", {14'd0, arb_adrs}, 32'h155);
    for (int i = 0; i < 3; i++) begin
      wr(18'h00200 + 18'(i), 8'h60 + 8'(i));
    end
    chk("rr_count", {29'd0, count}, 32'd3);
    chk("rr_still_read", {31'd0, arb_read}, 32'd1);
    chk("rr_no_write", {31'd0, arb_write}, 32'd0);
    rd(18'h00300);
    chk("rr_ovf", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_read_off", {31'd0, arb_read}, 32'd0);
    chk("rr_count0", {29'd0, count}, 32'd0);
    chk("rr_adrs0", {14'd0, arb_adrs}, 32'd0);
    chk("rr_ovf0", {31'd0, overflow}, 32'd0);
    chk("rr_rd_data0", {24'd0, rd_data}, 32'd0);
    tick();
    arb_rd_data = 8'hEE;
    arb_rd_ack  = 1'b1;
    tick();
    arb_rd_ack  = 1'b0;
    chk("rr_late_ack", {31'd0, rd_valid}, 32'd0);
    chk("rr_late_data", {24'd0, rd_data}, 32'd0);
    tick();
    chk("rr_late_ack2", {31'd0, rd_valid}, 32'd0);
    chk("rr_idle", {31'd0, arb_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
